// File: rtl/jelly2_video_pkg.sv
// jelly2_video_pkg: shared types for the jelly2 video stream stages
package jelly2_video_pkg;
  typedef enum logic [2:0] {WAIT_SOF, RUN, PAD_LINE, PAD_FRAME, SKIP_LINE} frame_norm_state_t;
endpackage

// File: rtl/jelly2_video_frame_normalizer.sv
// jelly2_video_frame_normalizer: reshapes an AXI4-Stream video stream into exact W x H frames
// by padding short lines/frames with a fill pixel and discarding long lines and pre-SOF beats.
module jelly2_video_frame_normalizer
  import jelly2_video_pkg::*;
#(
  parameter int TUSER_WIDTH = 1,
  parameter int COMPONENTS  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_X_WIDTH = 10,
  parameter int IMG_Y_WIDTH = 9
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              aclken,
  input  logic [IMG_X_WIDTH-1:0]            param_img_width,
  input  logic [IMG_Y_WIDTH-1:0]            param_img_height,
  input  logic [COMPONENTS*DATA_WIDTH-1:0]  param_fill,
  input  logic [TUSER_WIDTH-1:0]            s_axi4s_tuser,
  input  logic                              s_axi4s_tlast,
  input  logic [COMPONENTS*DATA_WIDTH-1:0]  s_axi4s_tdata,
  input  logic                              s_axi4s_tvalid,
  output logic                              s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]            m_axi4s_tuser,
  output logic                              m_axi4s_tlast,
  output logic [COMPONENTS*DATA_WIDTH-1:0]  m_axi4s_tdata,
  output logic                              m_axi4s_tvalid,
  input  logic                              m_axi4s_tready,
  output logic                              out_pad,
  output logic                              out_skip
);
  localparam int TW = COMPONENTS * DATA_WIDTH;
  frame_norm_state_t r_state, w_next;
  logic [IMG_X_WIDTH-1:0] r_x, r_w, w_w, w_x_next;
  logic [IMG_Y_WIDTH-1:0] r_y, r_h, w_h, w_y_next;
  logic [TW-1:0] r_fill, w_data;
  logic [TUSER_WIDTH-1:0] w_user;
  logic w_ce, w_sof, w_origin, w_xlast, w_ylast, w_consume, w_take, w_pad_beat, w_emit, w_latch;
  logic w_pad_evt, w_skip_evt;
  // While waiting for SOF the geometry comes straight from the params, since it is latched on that beat.
  always_comb begin
    w_ce       = aclken && (!m_axi4s_tvalid || m_axi4s_tready);
    w_sof      = s_axi4s_tuser[0];
    w_w        = r_state == WAIT_SOF ? (param_img_width  == '0 ? IMG_X_WIDTH'(1) : param_img_width)  : r_w;
    w_h        = r_state == WAIT_SOF ? (param_img_height == '0 ? IMG_Y_WIDTH'(1) : param_img_height) : r_h;
    w_origin   = r_x == '0 && r_y == '0;
    w_xlast    = r_x == w_w - IMG_X_WIDTH'(1);
    w_ylast    = r_y == w_h - IMG_Y_WIDTH'(1);
    w_consume  = r_state == WAIT_SOF || (r_state == RUN && !(w_sof && !w_origin)) || (r_state == SKIP_LINE && !w_sof);
    s_axi4s_tready = aresetn && w_ce && w_consume;
    w_take     = s_axi4s_tready && s_axi4s_tvalid;
    w_pad_beat = r_state == PAD_LINE || r_state == PAD_FRAME;
    w_emit     = w_ce && (w_pad_beat || (w_take && (r_state == RUN || (r_state == WAIT_SOF && w_sof))));
    w_latch    = r_state == WAIT_SOF && w_take && w_sof;
    w_x_next   = w_xlast ? '0 : r_x + IMG_X_WIDTH'(1);
    w_y_next   = w_xlast ? (w_ylast ? '0 : r_y + IMG_Y_WIDTH'(1)) : r_y;
    w_data     = w_pad_beat ? r_fill : s_axi4s_tdata;
    w_user     = w_pad_beat ? '0 : s_axi4s_tuser;
    w_user[0]  = w_origin;
  end
  always_comb begin
    w_next     = r_state;
    w_pad_evt  = 1'b0;
    w_skip_evt = 1'b0;
    if (w_ce) begin
      case (r_state)
        WAIT_SOF: if (s_axi4s_tvalid) begin
          if (w_sof) w_next = (w_xlast && w_ylast) ? WAIT_SOF : RUN;
          else w_skip_evt = 1'b1;
        end
        RUN: if (s_axi4s_tvalid) begin
          if (w_sof && !w_origin) begin
            w_next    = PAD_FRAME;
            w_pad_evt = 1'b1;
          end else if (w_xlast) begin
            if (w_ylast) w_next = WAIT_SOF;
            else if (!s_axi4s_tlast) begin
              w_next     = SKIP_LINE;
              w_skip_evt = 1'b1;
            end
          end else if (s_axi4s_tlast) begin
            w_next    = PAD_LINE;
            w_pad_evt = 1'b1;
          end
        end
        PAD_LINE:  if (w_xlast) w_next = w_ylast ? WAIT_SOF : RUN;
        PAD_FRAME: if (w_xlast && w_ylast) w_next = WAIT_SOF;
        SKIP_LINE: if (s_axi4s_tvalid) begin
          if (w_sof) begin
            w_next    = PAD_FRAME;
            w_pad_evt = 1'b1;
          end else if (s_axi4s_tlast) w_next = RUN;
        end
        default: w_next = WAIT_SOF;
      endcase
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state        <= WAIT_SOF;
      r_x            <= '0;
      r_y            <= '0;
      r_w            <= IMG_X_WIDTH'(1);
      r_h            <= IMG_Y_WIDTH'(1);
      r_fill         <= '0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tdata  <= '0;
      out_pad        <= 1'b0;
      out_skip       <= 1'b0;
    end else if (aclken) begin
      out_pad  <= w_pad_evt;
      out_skip <= w_skip_evt;
      if (w_ce) begin
        r_state        <= w_next;
        m_axi4s_tvalid <= w_emit;
        if (w_emit) begin
          r_x           <= w_x_next;
          r_y           <= w_y_next;
          m_axi4s_tuser <= w_user;
          m_axi4s_tlast <= w_xlast;
          m_axi4s_tdata <= w_data;
        end
        if (w_latch) begin
          r_w    <= w_w;
          r_h    <= w_h;
          r_fill <= param_fill;
        end
      end
    end
  end
endmodule

// File: tb/tb_jelly2_video_frame_normalizer.sv
// tb_jelly2_video_frame_normalizer: directed scoreboard bench for the frame normalizer
module tb_jelly2_video_frame_normalizer;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic [9:0]  param_img_width = 10'd4;
  logic [8:0]  param_img_height = 9'd2;
  logic [23:0] param_fill = 24'hF0F0F0;
  logic [0:0]  s_axi4s_tuser = '0;
  logic        s_axi4s_tlast = 1'b0;
  logic [23:0] s_axi4s_tdata = '0;
  logic        s_axi4s_tvalid = 1'b0;
  logic        s_axi4s_tready;
  logic [0:0]  m_axi4s_tuser;
  logic        m_axi4s_tlast;
  logic [23:0] m_axi4s_tdata;
  logic        m_axi4s_tvalid;
  logic        m_axi4s_tready = 1'b1;
  logic        out_pad, out_skip;

  jelly2_video_frame_normalizer dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .param_img_width(param_img_width), .param_img_height(param_img_height), .param_fill(param_fill),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast), .s_axi4s_tdata(s_axi4s_tdata),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast), .m_axi4s_tdata(m_axi4s_tdata),
    .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready),
    .out_pad(out_pad), .out_skip(out_skip)
  );

  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail = 0;
  int pad_cnt = 0;
  int skip_cnt = 0;
  logic rnd = 1'b0;
  logic [31:0] q[$];
  logic        stalled = 1'b0;
  logic [31:0] stall_beat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic u, input logic l, input logic [23:0] d);
    return {6'd0, u, l, d};
  endfunction

  function automatic logic [23:0] px(input int f, input int l, input int p);
    return {8'(f), 8'(l), 8'(p)};
  endfunction

  always @(negedge aclk) begin
    if (out_pad) pad_cnt++;
    if (out_skip) skip_cnt++;
    if (stalled && aresetn) begin
      chk("stall_valid", 32'(m_axi4s_tvalid), 32'd1);
      chk("stall_payload", beat(m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata), stall_beat);
    end
    if (aresetn && aclken && m_axi4s_tvalid && m_axi4s_tready) begin
      if (q.size() == 0) chk("unexpected_beat", beat(m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata), 32'hFFFFFFFF);
      else chk("beat", beat(m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata), q.pop_front());
    end
    stalled    = aresetn && m_axi4s_tvalid && !(m_axi4s_tready && aclken);
    stall_beat = beat(m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rnd) m_axi4s_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [23:0] d, input logic sof, input logic last, output int waits);
    logic acc;
    s_axi4s_tdata  = d;
    s_axi4s_tuser  = sof;
    s_axi4s_tlast  = last;
    s_axi4s_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge aclk);
      acc = s_axi4s_tready;
      tick();
      if (acc) break;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    s_axi4s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int f, input int l, input int n, input logic sof, input logic last);
    int w;
    for (int p = 0; p < n; p++) send(px(f, l, p), sof && p == 0, last && p == n - 1, w);
  endtask

  task automatic push_line(input int f, input int l, input logic sof);
    for (int p = 0; p < 4; p++) q.push_back(beat(sof && p == 0, p == 3, px(f, l, p)));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    rnd = 1'b0;
    m_axi4s_tready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int w, p0, s0;
    repeat (3) begin
      @(negedge aclk);
      chk("rst_tready", 32'(s_axi4s_tready), 32'd0);
    end
    chk("rst_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("rst_tuser", 32'(m_axi4s_tuser), 32'd0);
    chk("rst_tlast", 32'(m_axi4s_tlast), 32'd0);
    chk("rst_tdata", 32'(m_axi4s_tdata), 32'd0);
    chk("rst_pad", 32'(out_pad), 32'd0);
    chk("rst_skip", 32'(out_skip), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // clean frame, full throughput, 1-cycle latency
    p0 = pad_cnt; s0 = skip_cnt;
    push_line(1, 0, 1'b1);
    push_line(1, 1, 1'b0);
    send(px(1, 0, 0), 1'b1, 1'b0, w);
    chk("latency_valid", 32'(m_axi4s_tvalid), 32'd1);
    chk("clean_wait", 32'(w), 32'd0);
    for (int i = 1; i < 8; i++) begin
      send(px(1, i / 4, i % 4), 1'b0, (i % 4) == 3, w);
      chk("clean_wait", 32'(w), 32'd0);
    end
    drain();
    chk("clean_pad", 32'(pad_cnt - p0), 32'd0);
    chk("clean_skip", 32'(skip_cnt - s0), 32'd0);

    // short line padded with fill
    p0 = pad_cnt; s0 = skip_cnt;
    q.push_back(beat(1'b1, 1'b0, px(2, 0, 0)));
    q.push_back(beat(1'b0, 1'b0, px(2, 0, 1)));
    q.push_back(beat(1'b0, 1'b0, 24'hF0F0F0));
    q.push_back(beat(1'b0, 1'b1, 24'hF0F0F0));
    push_line(2, 1, 1'b0);
    send_line(2, 0, 2, 1'b1, 1'b1);
    send_line(2, 1, 4, 1'b0, 1'b1);
    drain();
    chk("short_pad", 32'(pad_cnt - p0), 32'd1);
    chk("short_skip", 32'(skip_cnt - s0), 32'd0);

    // long line truncated with forced tlast
    p0 = pad_cnt; s0 = skip_cnt;
    push_line(3, 0, 1'b1);
    push_line(3, 1, 1'b0);
    send_line(3, 0, 6, 1'b1, 1'b1);
    send_line(3, 1, 4, 1'b0, 1'b1);
    drain();
    chk("long_pad", 32'(pad_cnt - p0), 32'd0);
    chk("long_skip", 32'(skip_cnt - s0), 32'd1);

    // early SOF pads out the frame, then starts the next one
    p0 = pad_cnt; s0 = skip_cnt;
    push_line(4, 0, 1'b1);
    q.push_back(beat(1'b0, 1'b0, px(4, 1, 0)));
    q.push_back(beat(1'b0, 1'b0, 24'hF0F0F0));
    q.push_back(beat(1'b0, 1'b0, 24'hF0F0F0));
    q.push_back(beat(1'b0, 1'b1, 24'hF0F0F0));
    push_line(5, 0, 1'b1);
    push_line(5, 1, 1'b0);
    send_line(4, 0, 4, 1'b1, 1'b1);
    send_line(4, 1, 1, 1'b0, 1'b0);
    send_line(5, 0, 4, 1'b1, 1'b1);
    send_line(5, 1, 4, 1'b0, 1'b1);
    drain();
    chk("early_sof_pad", 32'(pad_cnt - p0), 32'd1);
    chk("early_sof_skip", 32'(skip_cnt - s0), 32'd0);

    // garbage before SOF is swallowed
    p0 = pad_cnt; s0 = skip_cnt;
    for (int i = 0; i < 3; i++) send(px(6, 9, i), 1'b0, 1'b0, w);
    push_line(6, 0, 1'b1);
    push_line(6, 1, 1'b0);
    send_line(6, 0, 4, 1'b1, 1'b1);
    send_line(6, 1, 4, 1'b0, 1'b1);
    drain();
    chk("presof_skip", 32'(skip_cnt - s0), 32'd3);
    chk("presof_pad", 32'(pad_cnt - p0), 32'd0);

    // random backpressure with a clock-enable pause mid-frame
    rnd = 1'b1;
    push_line(7, 0, 1'b1);
    push_line(7, 1, 1'b0);
    send_line(7, 0, 3, 1'b1, 1'b0);
    aclken = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("ce_low_tready", 32'(s_axi4s_tready), 32'd0);
      tick();
    end
    aclken = 1'b1;
    send(px(7, 0, 3), 1'b0, 1'b1, w);
    send_line(7, 1, 4, 1'b0, 1'b1);
    drain();

    // reset mid-frame drops the held beat and returns to WAIT_SOF
    q.push_back(beat(1'b1, 1'b0, px(8, 0, 0)));
    q.push_back(beat(1'b0, 1'b0, px(8, 0, 1)));
    send_line(8, 0, 3, 1'b1, 1'b0);
    m_axi4s_tready = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("midrst_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("midrst_tready", 32'(s_axi4s_tready), 32'd0);
    aresetn = 1'b1;
    m_axi4s_tready = 1'b1;
    tick();
    chk("midrst_queue", 32'(q.size()), 32'd0);
    s0 = skip_cnt;
    send(px(8, 0, 3), 1'b0, 1'b1, w);
    push_line(9, 0, 1'b1);
    push_line(9, 1, 1'b0);
    send_line(9, 0, 4, 1'b1, 1'b1);
    send_line(9, 1, 4, 1'b0, 1'b1);
    drain();
    chk("midrst_skip", 32'(skip_cnt - s0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
